// File: rtl/if_id_reg_pkg.sv
// Shared constants for the IF/ID pipeline register slice.
// Bubble encoding and datapath width used across the front end.
package if_id_reg_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INST  = 32'h0000_0013;
    localparam bit          RUN_TRACE = 1'b0;

endpackage

// File: rtl/if_id_reg_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Holds at all-ones instead of wrapping.
module if_id_reg_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_full;

    assign w_full = &r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_inc && !w_full) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load, stall-hold, flush-to-bubble,
// plus saturating stall/flush event counters.
module if_id_reg
    import if_id_reg_pkg::*;
#(
    parameter int              XLEN_P     = XLEN,
    parameter logic [XLEN_P-1:0] NOP_INST_P = XLEN_P'(NOP_INST),
    parameter int              CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN_P-1:0] if_pc,
    input  logic [XLEN_P-1:0] if_inst,
    input  logic              if_valid,
    input  logic              data_hazard,
    input  logic              flush,
    output logic [XLEN_P-1:0] id_pc,
    output logic [XLEN_P-1:0] id_pc4,
    output logic [XLEN_P-1:0] id_inst,
    output logic              id_valid,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic [XLEN_P-1:0] r_pc;
    logic [XLEN_P-1:0] r_pc4;
    logic [XLEN_P-1:0] r_inst;
    logic              r_valid;

    logic              w_stall_ev;
    logic [XLEN_P-1:0] w_pc4;

    // a squashed instruction must never be held, so flush masks the stall
    assign w_stall_ev = data_hazard & ~flush;
    assign w_pc4      = if_pc + XLEN_P'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= '0;
            r_pc4   <= '0;
            r_inst  <= NOP_INST_P;
            r_valid <= 1'b0;
        end else if (flush) begin
            r_pc    <= '0;
            r_pc4   <= '0;
            r_inst  <= NOP_INST_P;
            r_valid <= 1'b0;
        end else if (!data_hazard) begin
            r_pc    <= if_pc;
            r_pc4   <= w_pc4;
            r_inst  <= if_inst;
            r_valid <= if_valid;
        end
    end

    assign id_pc    = r_pc;
    assign id_pc4   = r_pc4;
    assign id_inst  = r_inst;
    assign id_valid = r_valid;

    if_id_reg_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .i_clk (clk),
        .i_rst (rst),
        .i_inc (w_stall_ev),
        .o_cnt (stall_cnt)
    );

    if_id_reg_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .i_clk (clk),
        .i_rst (rst),
        .i_inc (flush),
        .o_cnt (flush_cnt)
    );

endmodule

// File: tb/tb_if_id_reg.sv
// Bench for if_id_reg: reference model compared every cycle on
// two instances (32-bit and 3-bit counters) plus literal spot checks.
module tb_if_id_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        data_hazard;
    logic        flush;

    logic [31:0] id_pc, id_pc4, id_inst;
    logic        id_valid;
    logic [31:0] stall_cnt, flush_cnt;

    logic [31:0] s_pc, s_pc4, s_inst;
    logic        s_valid;
    logic [2:0]  s_stall_cnt, s_flush_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_id_reg #(.CNT_W(32)) dut_big (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_inst(if_inst),
        .if_valid(if_valid), .data_hazard(data_hazard), .flush(flush),
        .id_pc(id_pc), .id_pc4(id_pc4), .id_inst(id_inst),
        .id_valid(id_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    if_id_reg #(.CNT_W(3)) dut_small (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_inst(if_inst),
        .if_valid(if_valid), .data_hazard(data_hazard), .flush(flush),
        .id_pc(s_pc), .id_pc4(s_pc4), .id_inst(s_inst),
        .id_valid(s_valid), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the decode stage must see, from the rules.
    bit          m_on = 0;
    logic [31:0] m_pc, m_pc4, m_inst;
    logic        m_valid;
    longint      m_sc, m_fc;
    localparam longint BIG_MAX   = 64'hFFFF_FFFF;
    localparam longint SMALL_MAX = 7;

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pc = 0; m_pc4 = 0; m_inst = 32'h13; m_valid = 0;
            m_sc = 0; m_fc = 0; m_on = 1;
        end else if (m_on) begin
            if (flush) begin
                m_fc++;
                m_pc = 0; m_pc4 = 0; m_inst = 32'h13; m_valid = 0;
            end else if (data_hazard) begin
                m_sc++;
            end else begin
                m_pc    = if_pc;
                m_pc4   = 32'((64'(if_pc) + 64'd4) % 64'h1_0000_0000);
                m_inst  = if_inst;
                m_valid = if_valid;
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("pc",        64'(id_pc),     64'(m_pc));
            chk("pc4",       64'(id_pc4),    64'(m_pc4));
            chk("inst",      64'(id_inst),   64'(m_inst));
            chk("valid",     64'(id_valid),  64'(m_valid));
            chk("stall_cnt", 64'(stall_cnt), 64'(sat(m_sc, BIG_MAX)));
            chk("flush_cnt", 64'(flush_cnt), 64'(sat(m_fc, BIG_MAX)));
            chk("s_inst",    64'(s_inst),    64'(m_inst));
            chk("s_valid",   64'(s_valid),   64'(m_valid));
            chk("s_stall",   64'(s_stall_cnt), 64'(sat(m_sc, SMALL_MAX)));
            chk("s_flush",   64'(s_flush_cnt), 64'(sat(m_fc, SMALL_MAX)));
        end
    end

    task automatic drive(input logic r, input logic [31:0] pc,
                         input logic [31:0] inst, input logic v,
                         input logic dh, input logic fl);
        rst = r; if_pc = pc; if_inst = inst; if_valid = v;
        data_hazard = dh; flush = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; if_pc = 32'h100; if_inst = 32'h00500093;
        if_valid = 1; data_hazard = 0; flush = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("L_rst_inst",  64'(id_inst),   64'h13);
        chk("L_rst_valid", 64'(id_valid),  64'h0);
        chk("L_rst_pc",    64'(id_pc),     64'h0);
        chk("L_rst_sc",    64'(stall_cnt), 64'h0);
        chk("L_rst_fc",    64'(flush_cnt), 64'h0);

        drive(0, 32'h4, 32'h00a00113, 1, 0, 0);
        chk("L_ld_pc",    64'(id_pc),    64'h4);
        chk("L_ld_pc4",   64'(id_pc4),   64'h8);
        chk("L_ld_inst",  64'(id_inst),  64'h00a00113);
        chk("L_ld_valid", 64'(id_valid), 64'h1);

        for (int i = 0; i < 3; i++) begin
            drive(0, 32'h8 + 32'(i * 4), 32'h11100093 + 32'(i), 1, 1, 0);
            chk("L_stall_pc",   64'(id_pc),   64'h4);
            chk("L_stall_inst", 64'(id_inst), 64'h00a00113);
        end
        chk("L_stall_cnt", 64'(stall_cnt), 64'd3);

        drive(0, 32'h20, 32'h00300193, 1, 0, 0);
        chk("L_rel_pc",   64'(id_pc),   64'h20);
        chk("L_rel_inst", 64'(id_inst), 64'h00300193);

        drive(0, 32'h24, 32'h00400213, 1, 1, 1);
        chk("L_fl_inst",  64'(id_inst),   64'h13);
        chk("L_fl_valid", 64'(id_valid),  64'h0);
        chk("L_fl_fc",    64'(flush_cnt), 64'd1);
        chk("L_fl_sc",    64'(stall_cnt), 64'd3);

        drive(0, 32'hFFFF_FFFC, 32'h00000033, 1, 0, 0);
        chk("L_wrap_pc",  64'(id_pc),  64'hFFFF_FFFC);
        chk("L_wrap_pc4", 64'(id_pc4), 64'h0);

        drive(0, 32'h30, 32'h00100093, 0, 0, 0);
        chk("L_inv_inst",  64'(id_inst),  64'h00100093);
        chk("L_inv_valid", 64'(id_valid), 64'h0);

        for (int i = 0; i < 9; i++)
            drive(0, 32'h40 + 32'(i * 4), 32'h0, 1, 1, 0);
        chk("L_sat_small", 64'(s_stall_cnt), 64'd7);
        chk("L_sat_big",   64'(stall_cnt),   64'd12);

        drive(1, 32'h50, 32'h0, 1, 1, 0);
        chk("L_rst_mid_s", 64'(s_stall_cnt), 64'd0);
        chk("L_rst_mid_b", 64'(stall_cnt),   64'd0);

        drive(0, 32'h54, 32'h00200093, 1, 0, 0);
        chk("L_post_pc",   64'(id_pc),   64'h54);
        chk("L_post_pc4",  64'(id_pc4),  64'h58);

        drive(0, 32'h58, 32'h00000013, 1, 0, 1);
        drive(0, 32'h5C, 32'h12345678, 1, 1, 0);
        drive(0, 32'h60, 32'h0badc0de, 1, 0, 0);
        for (int i = 0; i < 8; i++)
            drive(0, 32'h70 + 32'(i * 4), 32'hA000_0000 + 32'(i), 1, 0, 1);
        chk("L_fsat_small", 64'(s_flush_cnt), 64'd7);
        chk("L_fsat_big",   64'(flush_cnt),   64'd9);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
